aes_key_expand: RTL

- Sequential AES-128 key schedule generator that produces round keys 0..10 one at a time.
- Sits directly upstream of addRoundKey in the AES datapath; its round_key output drives addRoundKey's roundKey input.
- The consumer requests each new round key with a valid/next handshake.
- S-box lookups use the synchronous S-box (one-cycle read latency), so each round key costs a two-cycle compute phase.

---
 rtl/aes_pkg.sv | 28 ++
 rtl/sbox_sync.sv | 35 +++
 rtl/sub_word.sv | 19 +
 rtl/aes_key_expand.sv | 101 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the sequential AES-128 key schedule.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package aes_pkg;

    // Key schedule controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SUB  = 2'd2,
        MIX  = 2'd3
    } state_t;

    // Number of expansion rounds after round 0 for a 128-bit key
    localparam int NR = 10;

    // Round constants indexed by the round number being left (0..NR-1)
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // RotWord: one-byte cyclic left rotation of a big-endian word
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/sbox_sync.sv
// AES forward S-box as a registered lookup table.
// Latency: one cycle from addr to data.
// Backpressure: none; a new address is accepted every cycle.
module sbox_sync (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // Entry 0 sits in the most significant byte, entry 255 in the least.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Registered read; {~addr,3'b111} is the top bit of entry addr
    always_ff @(posedge clk) begin
        data <= SBOX_TBL[{~addr, 3'b111} -: 8];
    end

endmodule

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Latency: one cycle, output registered inside the S-box instances.
// Backpressure: none; streams one word per cycle.
module sub_word (
    input  logic        clk,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // One synchronous S-box per byte lane
    for (genvar i = 0; i < 4; i++) begin : g_lane
        sbox_sync u_sbox (
            .clk  (clk),
            .addr (din[8*i +: 8]),
            .data (dout[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key schedule: emits round keys 0..NR one per request.
// Latency: start -> valid next cycle; accepted next -> valid after 3 edges.
// Backpressure: holds round_key/round_num/valid while next is low in HOLD.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         valid,
    output logic         done
);

    localparam logic [3:0] LAST_ROUND = NR[3:0];

    state_t       state;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [7:0]   rcon_byte;
    logic [31:0]  t_word;
    logic [31:0]  w0_n;
    logic [31:0]  w1_n;
    logic [31:0]  w2_n;
    logic [31:0]  w3_n;

    // RotWord of w3 feeds the S-boxes continuously; round_key is stable in
    // HOLD and SUB, so the value captured on the SUB->MIX edge is the one
    // belonging to the current round.
    assign sub_in = rot_word(round_key[31:0]);

    sub_word u_sub_word (
        .clk  (clk),
        .din  (sub_in),
        .dout (sub_out)
    );

    // Next round key: rcon mix into the SubWord result, then the XOR chain
    always_comb begin
        rcon_byte = 8'h00;
        if (round_num < LAST_ROUND) begin
            rcon_byte = RCON[round_num];
        end
        t_word = sub_out ^ {rcon_byte, 24'h000000};
        w0_n   = round_key[127:96] ^ t_word;
        w1_n   = round_key[95:64]  ^ w0_n;
        w2_n   = round_key[63:32]  ^ w1_n;
        w3_n   = round_key[31:0]   ^ w2_n;
    end

    // Schedule controller: reset beats start, start beats next in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_key <= '0;
            round_num <= '0;
            valid     <= 1'b0;
        end else if (start) begin
            state     <= HOLD;
            round_key <= key;
            round_num <= '0;
            valid     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                end
                HOLD: begin
                    if (next) begin
                        valid <= 1'b0;
                        if (round_num == LAST_ROUND) begin
                            state <= IDLE;
                        end else begin
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    state <= MIX;
                end
                MIX: begin
                    round_key <= {w0_n, w1_n, w2_n, w3_n};
                    round_num <= round_num + 4'd1;
                    valid     <= 1'b1;
                    state     <= HOLD;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    // Final key flag derived straight from the registered outputs
    assign done = valid && (round_num == LAST_ROUND);

endmodule
